dm_responder: RTL

Memory-side responder for the multicycle CPU's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and inserts a fixed number of wait states. It performs byte, half-word or word access with little-endian lane selection and sign or zero extension, then returns a response over a second valid/ready handshake. It replaces the zero-latency data memory when slow memory must be modelled, and sits between the CPU's ALUOut/B-register datapath and the storage array.

---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_lane_extract.sv | 29 ++
 rtl/dm_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size codes, FSM states and alignment helper for the
// data-memory responder slice.
package dm_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dmState_t;

    // Half needs an even address; word (and the 2'b11 alias) needs addr[1:0] == 0.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addrLo[0];
            default: bad = (addrLo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_lane_extract.sv
// dm_lane_extract: little-endian lane select plus sign/zero extension of a
// 32-bit memory word for byte, half-word and word loads.
module dm_lane_extract
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isSigned,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [15:0] halfVal;

    assign shifted = word >> {addrLo, 3'b000};
    assign halfVal = addrLo[1] ? word[31:16] : word[15:0];

    // Pick the addressed lane(s) and extend to 32 bits.
    always_comb begin
        data = word;
        case (size)
            SZ_BYTE: data = {{24{isSigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{isSigned & halfVal[15]}}, halfVal};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: wait-state data-memory responder for the multicycle CPU.
// One request at a time: accept -> WAIT_CYCLES wait states -> access -> response.
// Optional misaligned-access check is enabled by defining DM_ALIGN_CHECK_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmState_t state, stateNext;

    logic [3:0]        waitCnt;
    logic              wrQ;
    logic [1:0]        sizeQ;
    logic              signedQ;
    logic [ADDR_W+1:0] addrQ;
    logic [31:0]       wdataQ;
    logic [31:0]       rdataQ;
    logic              errQ;

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       curWord;
    logic [31:0]       mergedWord;
    logic [31:0]       loadData;
    logic              accessMisaligned;
    logic              accept;
    logic              unusedAddrHi;

    // Upper address bits wrap away: only the word index and lane bits are kept.
    assign unusedAddrHi = ^req_addr[31:ADDR_W+2];

    assign wordIdx = addrQ[ADDR_W+1:2];
    assign curWord = mem[wordIdx];

`ifdef DM_ALIGN_CHECK_EN
    assign accessMisaligned = isMisaligned(sizeQ, addrQ[1:0]);
`else
    assign accessMisaligned = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    // Next-state and handshake decode.
    always_comb begin
        stateNext = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    stateNext = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (waitCnt <= 4'd1) stateNext = ST_ACCESS;
            end
            ST_ACCESS: stateNext = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Request capture; these are only consumed after acceptance, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            wrQ     <= req_wr;
            sizeQ   <= req_size;
            signedQ <= req_signed;
            addrQ   <= req_addr[ADDR_W+1:0];
            wdataQ  <= req_wdata;
        end
    end

    // Wait counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
            rdataQ  <= '0;
            errQ    <= 1'b0;
        end else begin
            if (accept)
                waitCnt <= WAIT_INIT;
            else if (state == ST_WAIT)
                waitCnt <= waitCnt - 4'd1;

            if (state == ST_ACCESS) begin
                rdataQ <= (wrQ || accessMisaligned) ? '0 : loadData;
                errQ   <= accessMisaligned;
            end else if (state == ST_RESP && rsp_ready) begin
                rdataQ <= '0;
                errQ   <= 1'b0;
            end
        end
    end

    // Store merge: overlay the active byte lanes of the store data on the current word.
    always_comb begin
        mergedWord = curWord;
        case (sizeQ)
            SZ_BYTE: mergedWord[{addrQ[1:0], 3'b000} +: 8]  = wdataQ[7:0];
            SZ_HALF: mergedWord[{addrQ[1], 4'b0000} +: 16] = wdataQ[15:0];
            default: mergedWord = wdataQ;
        endcase
    end

    // Array write; deliberately not gated by rst so a store in ACCESS always lands.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && wrQ && !accessMisaligned)
            mem[wordIdx] <= mergedWord;
    end

    dm_lane_extract uLaneExtract (
        .word    (curWord),
        .addrLo  (addrQ[1:0]),
        .size    (sizeQ),
        .isSigned(signedQ),
        .data    (loadData)
    );

    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rdataQ;
`ifdef DM_ALIGN_CHECK_EN
    assign rsp_err   = errQ;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
